spi_slave: RTL and testbench

//   SPI slave byte transceiver, mode-0 style. Clocked directly by the SPI serial clock.

---
 rtl/spi_slave.sv | 77 +++++++
 tb/tb_spi_slave.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
//==============================================================================
// Module      : spi_slave
// Description : SPI mode-0 slave byte transceiver clocked directly by SCLK.
//               Shifts MSB first on MOSI/MISO while CS is low and hands
//               complete bytes to the parallel side. Back-to-back bytes
//               reload the transmit byte without a CS toggle.
//               Optional feature macro: MISO_TRISTATE_EN (MISO floats while
//               CS is high instead of driving 0).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module spi_slave #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] slaveDataToSend,
    output logic [WIDTH-1:0] slaveDataReceived,
    input  logic             CS,
    input  logic             MOSI,
    output logic             MISO
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shifted;

    // Next-state: preload while idle, shift while selected, deliver and reload at byte end.
    always_comb begin
        shifted = {shift_q[WIDTH-2:0], MOSI};
        shift_d = shift_q;
        rx_d    = rx_q;
        cnt_d   = cnt_q;
        if (CS) begin
            // Deselected: a mid-byte abort lands here too, discarding partial bits.
            shift_d = slaveDataToSend;
            cnt_d   = '0;
        end else if (cnt_q == LAST_BIT) begin
            rx_d    = shifted;
            shift_d = slaveDataToSend;
            cnt_d   = '0;
        end else begin
            shift_d = shifted;
            cnt_d   = cnt_q + 1'b1;
        end
    end

    // State registers; reset clears everything immediately so no partial byte escapes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q <= '0;
            rx_q    <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            rx_q    <= rx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign slaveDataReceived = rx_q;

    // MISO presents the current MSB while selected; the idle level depends on the build.
`ifdef MISO_TRISTATE_EN
    assign MISO = CS ? 1'bz : shift_q[WIDTH-1];
`else
    assign MISO = CS ? 1'b0 : shift_q[WIDTH-1];
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_slave.sv
//==============================================================================
// Module      : tb_spi_slave
// Description : Directed self-checking bench for spi_slave (loopback and
//               external MOSI patterns, back-to-back, abort, mid-byte reset).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_spi_slave;

    logic       clk;
    logic       reset;
    logic [7:0] tx;
    logic [7:0] rx;
    logic       cs;
    logic       miso;
    logic       mosi_ext;
    logic       loop_en;
    logic       mosi;

    int n_vec;
    int n_err;

    assign mosi = loop_en ? miso : mosi_ext;

    spi_slave #(.WIDTH(8)) dut (
        .clk               (clk),
        .reset             (reset),
        .slaveDataToSend   (tx),
        .slaveDataReceived (rx),
        .CS                (cs),
        .MOSI              (mosi),
        .MISO              (miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expectation.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Hold CS high for one rising edge so the DUT preloads d; returns at a falling edge.
    task automatic preload(input logic [7:0] d);
        cs = 1'b1;
        tx = d;
        @(negedge clk);
    endtask

    // Run n active edges starting from a falling edge; optionally check each MISO bit.
    task automatic shift_bits(input int n, input int first, input logic [7:0] mosi_pat,
                              input logic [7:0] miso_exp, input bit chk_miso, input string tag);
        cs = 1'b0;
        for (int i = first; i < first + n; i++) begin
            mosi_ext = mosi_pat[7-i];
            #1;
            if (chk_miso) check_eq(tag, {31'd0, miso}, {31'd0, miso_exp[7-i]});
            @(negedge clk);
        end
    endtask

    logic idle_miso;

    initial begin
        n_vec    = 0;
        n_err    = 0;
        reset    = 1'b0;
        cs       = 1'b1;
        tx       = 8'h00;
        mosi_ext = 1'b0;
        loop_en  = 1'b0;
`ifdef MISO_TRISTATE_EN
        idle_miso = 1'bz;
`else
        idle_miso = 1'b0;
`endif

        // 1: reset held with random inputs, CS high.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tx       = 8'($urandom);
            mosi_ext = 1'($urandom);
            #1;
            check_eq("rst_rx", {24'd0, rx}, 32'h00);
            check_eq("rst_miso", {31'd0, miso}, {31'd0, idle_miso});
        end
        @(negedge clk);
        reset = 1'b1;

        // 2: loopback AA.
        loop_en = 1'b1;
        preload(8'hAA);
        shift_bits(8, 0, 8'h00, 8'hAA, 1'b1, "t2_miso");
        check_eq("t2_rx", {24'd0, rx}, 32'hAA);
        cs = 1'b1;
        #1;
        check_eq("t2_idle_miso", {31'd0, miso}, {31'd0, idle_miso});

        // 3: back-to-back F0 then 33 without CS toggle; tx changed mid-byte.
        @(negedge clk);
        preload(8'hF0);
        shift_bits(4, 0, 8'h00, 8'hF0, 1'b1, "t3_miso_a");
        tx = 8'h33;
        shift_bits(4, 4, 8'h00, 8'hF0, 1'b1, "t3_miso_a");
        check_eq("t3_rx_b1", {24'd0, rx}, 32'hF0);
        shift_bits(8, 0, 8'h00, 8'h33, 1'b1, "t3_miso_b");
        check_eq("t3_rx_b2", {24'd0, rx}, 32'h33);

        // 4: external MOSI 5C while transmitting C3.
        loop_en = 1'b0;
        preload(8'hC3);
        shift_bits(8, 0, 8'h5C, 8'hC3, 1'b1, "t4_miso");
        check_eq("t4_rx", {24'd0, rx}, 32'h5C);

        // 5: complete AA, abort a 0F after 5 bits, then a full 0F.
        loop_en = 1'b1;
        preload(8'hAA);
        shift_bits(8, 0, 8'h00, 8'hAA, 1'b0, "t5_pre");
        check_eq("t5_rx_aa", {24'd0, rx}, 32'hAA);
        preload(8'h0F);
        shift_bits(5, 0, 8'h00, 8'h0F, 1'b1, "t5_miso_part");
        preload(8'h0F);
        check_eq("t5_rx_abort", {24'd0, rx}, 32'hAA);
        shift_bits(8, 0, 8'h00, 8'h0F, 1'b1, "t5_miso_full");
        check_eq("t5_rx_full", {24'd0, rx}, 32'h0F);

        // 6: reset after 4 active edges, then a full transfer.
        preload(8'h3C);
        shift_bits(4, 0, 8'h00, 8'h3C, 1'b0, "t6_pre");
        reset = 1'b0;
        #1;
        check_eq("t6_rx_rst", {24'd0, rx}, 32'h00);
        check_eq("t6_miso_rst", {31'd0, miso}, 32'h0);
        @(negedge clk);
        cs = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        preload(8'h96);
        shift_bits(8, 0, 8'h00, 8'h96, 1'b1, "t6_miso");
        check_eq("t6_rx", {24'd0, rx}, 32'h96);
        cs = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
